edge_generator: RTL and testbench

Transmit-side counterpart of the edge detector. Accepts edge commands (rising/falling plus delay) over a valid/ready handshake and drives a single-bit line with the requested transition. Guarantees a minimum stable level after every transition, so a downstream 3-flop edge detector on another domain or pin sees every edge. Sits in soc/misc and drives GPIO-style strobe/handshake lines.

---
 rtl/edge_gen_pkg.sv | 16 +
 rtl/edge_generator.sv | 130 +++++++++++++
 tb/tb_edge_generator.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/edge_gen_pkg.sv
// edge_gen_pkg: shared types and constants for the edge_generator block.
//   edge_gen_state_t : controller state encoding (IDLE, DELAY, HOLD)
//   EDGE_FALLING     : cmd_type value requesting a 1->0 transition
//   EDGE_RISING      : cmd_type value requesting a 0->1 transition
package edge_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    HOLD  = 2'd2
  } edge_gen_state_t;

  localparam logic EDGE_FALLING = 1'b0;
  localparam logic EDGE_RISING  = 1'b1;

endpackage

// File: rtl/edge_generator.sv
// edge_generator: drives a single-bit line with commanded rising/falling
// transitions. Each command waits cmd_delay cycles, applies the transition,
// then holds the line stable for MIN_HOLD cycles so a slow multi-flop
// receiver on another domain is guaranteed to see every edge.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  block can accept a command (combinational, state == IDLE)
//   cmd_type   requested edge: 0 falling, 1 rising
//   cmd_delay  cycles to wait before the transition
//   data_out   generated line, registered
//   busy       command in progress (state != IDLE)
//   edge_done  one-cycle pulse on command completion
//   cmd_err    (only with EDGE_GENERATOR_ERR_EN) pulses with edge_done when
//              the completed command produced no transition
//
// Build option: define EDGE_GENERATOR_ERR_EN to add the cmd_err output.
//
// State table:
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready high
//   DELAY | counting down cmd_delay before the transition
//   HOLD  | line held stable for MIN_HOLD cycles after the transition
module edge_generator
  import edge_gen_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int MIN_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_type,
  input  logic [CNT_W-1:0] cmd_delay,
  output logic             data_out,
  output logic             busy,
  output logic             edge_done
`ifdef EDGE_GENERATOR_ERR_EN
  ,
  output logic             cmd_err
`endif
);

  // The hold counter is loaded with MIN_HOLD-1 because the zero-count cycle
  // itself is the last hold cycle.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MIN_HOLD - 1);

  edge_gen_state_t  r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_type;
  logic             r_data;
  logic             r_done;
  logic             w_cnt_zero;
  logic             w_accept;

`ifdef EDGE_GENERATOR_ERR_EN
  logic             r_redundant;
  logic             r_err;
`endif

  assign w_cnt_zero = (r_cnt == '0);
  assign cmd_ready  = (r_state == IDLE);
  assign w_accept   = cmd_valid && cmd_ready;
  assign busy       = (r_state != IDLE);
  assign data_out   = r_data;
  assign edge_done  = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_type      <= EDGE_FALLING;
      r_data      <= EDGE_FALLING;
      r_done      <= 1'b0;
`ifdef EDGE_GENERATOR_ERR_EN
      r_redundant <= 1'b0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef EDGE_GENERATOR_ERR_EN
      r_err  <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_type  <= cmd_type;
            r_cnt   <= cmd_delay;
            r_state <= DELAY;
          end
        end
        DELAY: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            // A redundant command rewrites the same level: no visible edge.
            r_data      <= r_type;
`ifdef EDGE_GENERATOR_ERR_EN
            r_redundant <= (r_type == r_data);
`endif
            r_cnt       <= HOLD_LOAD;
            r_state     <= HOLD;
          end
        end
        HOLD: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_state <= IDLE;
            r_done  <= 1'b1;
`ifdef EDGE_GENERATOR_ERR_EN
            r_err   <= r_redundant;
`endif
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef EDGE_GENERATOR_ERR_EN
  assign cmd_err = r_err;
`endif

endmodule

// File: tb/tb_edge_generator.sv
// tb_edge_generator: directed checks of edge_generator (MIN_HOLD=4 and a
// second MIN_HOLD=1 instance). A small 3-flop synchroniser plus edge
// detector on data_out plays the role of the downstream receiver.
// Build option: EDGE_GENERATOR_ERR_EN adds cmd_err checks.
module tb_edge_generator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_type, cmd_ready;
  logic [7:0] cmd_delay;
  logic       data_out, busy, edge_done;
`ifdef EDGE_GENERATOR_ERR_EN
  logic       cmd_err;
`endif

  logic       c1_valid, c1_type, c1_ready;
  logic [7:0] c1_delay;
  logic       d1_out, b1, done1;
`ifdef EDGE_GENERATOR_ERR_EN
  logic       err1;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_rise  = 0;
  int n_fall  = 0;
  logic seen;
  logic [2:0] s_sync = 3'b000;

  always #5 clk = ~clk;

  edge_generator #(.CNT_W(8), .MIN_HOLD(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_delay(cmd_delay), .data_out(data_out),
    .busy(busy), .edge_done(edge_done)
`ifdef EDGE_GENERATOR_ERR_EN
    , .cmd_err(cmd_err)
`endif
  );

  edge_generator #(.CNT_W(8), .MIN_HOLD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
    .cmd_type(c1_type), .cmd_delay(c1_delay), .data_out(d1_out),
    .busy(b1), .edge_done(done1)
`ifdef EDGE_GENERATOR_ERR_EN
    , .cmd_err(err1)
`endif
  );

  // Receiver: 3-flop synchroniser, edge flagged on the two oldest stages.
  always @(posedge clk) begin
    s_sync <= {s_sync[1:0], data_out};
    if (s_sync[1] && !s_sync[2]) n_rise <= n_rise + 1;
    if (!s_sync[1] && s_sync[2]) n_fall <= n_fall + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_type = 1'b0; cmd_delay = 8'd0;
    c1_valid = 1'b0; c1_type = 1'b0; c1_delay = 8'd0;
    tick();
    chk("rst data_out", data_out, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst edge_done", edge_done, 1'b0);
    chk("rst cmd_ready", cmd_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();

    // Rising, delay 0: transition one edge after accept, done 4 edges later.
    cmd_valid = 1'b1; cmd_type = 1'b1; cmd_delay = 8'd0;
    tick();
    cmd_valid = 1'b0;
    chk("t1 busy after accept", busy, 1'b1);
    chk("t1 ready after accept", cmd_ready, 1'b0);
    chk("t1 data_out N", data_out, 1'b0);
    tick();
    chk("t1 data_out N+1", data_out, 1'b1);
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk("t1 busy hold", {busy, edge_done}, 2'b10);
    end
    tick();
    chk("t1 edge_done N+5", edge_done, 1'b1);
    chk("t1 busy N+5", busy, 1'b0);
    chk("t1 ready N+5", cmd_ready, 1'b1);
    tick();
    chk("t1 edge_done N+6", edge_done, 1'b0);
    chk("t1 detector rise", n_rise, 32'd1);

    // Async reset while idle with data_out=1.
    #2 rst_n = 1'b0;
    #1 chk("idle reset data_out", data_out, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("idle reset detector fall", n_fall, 32'd1);

    // Redundant falling, delay 2: done 2+1+4 edges after accept.
    cmd_valid = 1'b1; cmd_type = 1'b0; cmd_delay = 8'd2;
    tick();
    cmd_valid = 1'b0;
    repeat (6) tick();
    chk("t3 busy A+6", busy, 1'b1);
    chk("t3 edge_done A+6", edge_done, 1'b0);
    tick();
    chk("t3 edge_done A+7", edge_done, 1'b1);
    chk("t3 data_out", data_out, 1'b0);
`ifdef EDGE_GENERATOR_ERR_EN
    chk("t3 cmd_err", cmd_err, 1'b1);
`endif
    tick();

    // Back-to-back: rising delay 5 then falling delay 0, valid held.
    cmd_valid = 1'b1; cmd_type = 1'b1; cmd_delay = 8'd5;
    tick();
    cmd_type = 1'b0; cmd_delay = 8'd0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("t2 data_out", data_out, (k >= 6 && k < 12) ? 1'b1 : 1'b0);
      if (k == 9) chk("t2 ready blocked", cmd_ready, 1'b0);
      if (k == 10) begin
        chk("t2 edge_done first", edge_done, 1'b1);
        chk("t2 ready after done", cmd_ready, 1'b1);
`ifdef EDGE_GENERATOR_ERR_EN
        chk("t2 cmd_err real edge", cmd_err, 1'b0);
`endif
      end
      if (k == 11) begin
        chk("t2 second accept", busy, 1'b1);
        cmd_valid = 1'b0;
      end
    end
    repeat (4) tick();
    chk("t2 edge_done second", edge_done, 1'b1);
    repeat (3) tick();
    chk("t2 detector rises", n_rise, 32'd2);
    chk("t2 detector falls", n_fall, 32'd2);

    // Maximum delay 255: transition exactly 256 edges after accept.
    cmd_valid = 1'b1; cmd_type = 1'b1; cmd_delay = 8'd255;
    tick();
    cmd_valid = 1'b0;
    repeat (255) tick();
    chk("t4 data_out A+255", data_out, 1'b0);
    chk("t4 busy A+255", busy, 1'b1);
    tick();
    chk("t4 data_out A+256", data_out, 1'b1);
    repeat (3) tick();
    chk("t4 edge_done A+259", edge_done, 1'b0);
    tick();
    chk("t4 edge_done A+260", edge_done, 1'b1);
    tick();

    // Reset mid-DELAY with data_out=1.
    cmd_valid = 1'b1; cmd_type = 1'b0; cmd_delay = 8'd10;
    tick();
    cmd_valid = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1 chk("t5 delay rst data_out", data_out, 1'b0);
    chk("t5 delay rst busy", busy, 1'b0);
    chk("t5 delay rst ready", cmd_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      tick();
      if (edge_done) seen = 1'b1;
    end
    chk("t5 delay rst no done", seen, 1'b0);

    // Reset mid-HOLD with data_out=1.
    cmd_valid = 1'b1; cmd_type = 1'b1; cmd_delay = 8'd0;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("t5 hold data_out set", data_out, 1'b1);
    tick();
    #2 rst_n = 1'b0;
    #1 chk("t5 hold rst data_out", data_out, 1'b0);
    chk("t5 hold rst busy", busy, 1'b0);
    chk("t5 hold rst ready", cmd_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (edge_done) seen = 1'b1;
    end
    chk("t5 hold rst no done", seen, 1'b0);
    chk("t5 hold rst busy later", busy, 1'b0);

    // Inputs toggled while busy (MIN_HOLD=4): latched rising delay 3 stands.
    cmd_valid = 1'b1; cmd_type = 1'b1; cmd_delay = 8'd3;
    tick();
    for (int k = 1; k <= 9; k++) begin
      cmd_valid = (k < 8) ? k[0] : 1'b0;
      cmd_type  = ~cmd_type;
      cmd_delay = 8'(k);
      tick();
      if (k == 3) chk("t6 data_out A+3", data_out, 1'b0);
      if (k == 4) chk("t6 data_out A+4", data_out, 1'b1);
      if (k == 7) chk("t6 edge_done A+7", edge_done, 1'b0);
      if (k == 8) chk("t6 edge_done A+8", edge_done, 1'b1);
      if (k == 9) chk("t6 no extra accept", busy, 1'b0);
    end

    // Same sequence on the MIN_HOLD=1 instance.
    c1_valid = 1'b1; c1_type = 1'b1; c1_delay = 8'd3;
    tick();
    for (int k = 1; k <= 6; k++) begin
      c1_valid = (k < 5) ? k[0] : 1'b0;
      c1_type  = ~c1_type;
      c1_delay = 8'(k);
      tick();
      if (k == 3) chk("t6h1 data_out A+3", d1_out, 1'b0);
      if (k == 4) chk("t6h1 data_out A+4", d1_out, 1'b1);
      if (k == 4) chk("t6h1 edge_done A+4", done1, 1'b0);
      if (k == 5) chk("t6h1 edge_done A+5", done1, 1'b1);
      if (k == 6) chk("t6h1 no extra accept", b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
